// File: rtl/pianissimo_keys_pkg.sv
// Shared key map definitions for the piano keyboard front end: key indices,
// PS/2 set-2 scancodes and the prefix-tracking FSM encoding.
package pianissimo_keys_pkg;

  localparam int NUM_KEYS = 29;
  localparam int KEY_IDX_W = 5;

  localparam logic [KEY_IDX_W-1:0] key0        = 5'd0;
  localparam logic [KEY_IDX_W-1:0] key1        = 5'd1;
  localparam logic [KEY_IDX_W-1:0] key2        = 5'd2;
  localparam logic [KEY_IDX_W-1:0] key3        = 5'd3;
  localparam logic [KEY_IDX_W-1:0] key4        = 5'd4;
  localparam logic [KEY_IDX_W-1:0] key5        = 5'd5;
  localparam logic [KEY_IDX_W-1:0] key6        = 5'd6;
  localparam logic [KEY_IDX_W-1:0] key7        = 5'd7;
  localparam logic [KEY_IDX_W-1:0] key8        = 5'd8;
  localparam logic [KEY_IDX_W-1:0] key9        = 5'd9;
  localparam logic [KEY_IDX_W-1:0] key10       = 5'd10;
  localparam logic [KEY_IDX_W-1:0] key11       = 5'd11;
  localparam logic [KEY_IDX_W-1:0] key12       = 5'd12;
  localparam logic [KEY_IDX_W-1:0] key13       = 5'd13;
  localparam logic [KEY_IDX_W-1:0] key14       = 5'd14;
  localparam logic [KEY_IDX_W-1:0] key15       = 5'd15;
  localparam logic [KEY_IDX_W-1:0] key16       = 5'd16;
  localparam logic [KEY_IDX_W-1:0] key17       = 5'd17;
  localparam logic [KEY_IDX_W-1:0] key18       = 5'd18;
  localparam logic [KEY_IDX_W-1:0] key19       = 5'd19;
  localparam logic [KEY_IDX_W-1:0] key20       = 5'd20;
  localparam logic [KEY_IDX_W-1:0] key21       = 5'd21;
  localparam logic [KEY_IDX_W-1:0] key22       = 5'd22;
  localparam logic [KEY_IDX_W-1:0] key23       = 5'd23;
  localparam logic [KEY_IDX_W-1:0] key24       = 5'd24;
  localparam logic [KEY_IDX_W-1:0] key25       = 5'd25;
  localparam logic [KEY_IDX_W-1:0] key26       = 5'd26;
  localparam logic [KEY_IDX_W-1:0] key27       = 5'd27;
  localparam logic [KEY_IDX_W-1:0] keySpacebar = 5'd28;

  // Protocol bytes; everything not in the key map is silently ignored.
  localparam logic [7:0] scBreak   = 8'hF0;
  localparam logic [7:0] scExtend  = 8'hE0;
  localparam logic [7:0] scPause   = 8'hE1;
  localparam logic [7:0] scBatOk   = 8'hAA;
  localparam logic [7:0] scAck     = 8'hFA;
  localparam logic [7:0] scResend  = 8'hFE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } trackState_t;

  function automatic logic isPrefix(input logic [7:0] code);
    return (code == scBreak) || (code == scExtend);
  endfunction

endpackage

// File: rtl/key_state_tracker_if.sv
// Byte-in / key-state-out bundle between the PS/2 receiver side (master)
// and the key state tracker (slave).
interface key_state_tracker_if;
  import pianissimo_keys_pkg::*;

  logic [7:0]           ps2_byte;
  logic                 ps2_byte_valid;
  logic                 clear_all;
  logic [NUM_KEYS-1:0]  key_state;
  logic                 key_event_valid;
  logic [KEY_IDX_W-1:0] key_event_index;
  logic                 key_event_press;

  modport master (
    output ps2_byte, ps2_byte_valid, clear_all,
    input  key_state, key_event_valid, key_event_index, key_event_press
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid, clear_all,
    output key_state, key_event_valid, key_event_index, key_event_press
  );

endinterface

// File: rtl/key_scancode_decoder.sv
// Combinational PS/2 set-2 scancode to piano key index lookup.
module key_scancode_decoder
  import pianissimo_keys_pkg::*;
(
  input  logic [7:0]           code,
  output logic                 hit,
  output logic [KEY_IDX_W-1:0] index
);

  always_comb begin
    hit   = 1'b1;
    index = key0;
    unique case (code)
      8'h45:   index = key0;
      8'h16:   index = key1;
      8'h1E:   index = key2;
      8'h26:   index = key3;
      8'h25:   index = key4;
      8'h2E:   index = key5;
      8'h36:   index = key6;
      8'h3D:   index = key7;
      8'h3E:   index = key8;
      8'h46:   index = key9;
      8'h0E:   index = key10;
      8'h4E:   index = key11;
      8'h55:   index = key12;
      8'h66:   index = key13;
      8'h0D:   index = key14;
      8'h15:   index = key15;
      8'h1D:   index = key16;
      8'h24:   index = key17;
      8'h2D:   index = key18;
      8'h2C:   index = key19;
      8'h35:   index = key20;
      8'h3C:   index = key21;
      8'h43:   index = key22;
      8'h44:   index = key23;
      8'h4D:   index = key24;
      8'h54:   index = key25;
      8'h5B:   index = key26;
      8'h5D:   index = key27;
      8'h29:   index = keySpacebar;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_state_tracker.sv
// Turns the PS/2 scancode byte stream into a held-key vector, tracking
// make/break/extended prefixes. Key change events exist only with KEY_TRACKER_EVENT_EN.
module key_state_tracker
  import pianissimo_keys_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  key_state_tracker_if.slave bus
);

  localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PREFIX_TIMEOUT);

  trackState_t          state, stateNext;
  logic [CNT_W-1:0]     toCnt, toCntNext;
  logic [NUM_KEYS-1:0]  keyState;
  logic                 decHit;
  logic [KEY_IDX_W-1:0] decIdx;
  logic                 setKey, clrKey;
  logic                 keyHeld;

  key_scancode_decoder uDecoder (
    .code  (bus.ps2_byte),
    .hit   (decHit),
    .index (decIdx)
  );

  assign keyHeld = decHit && keyState[decIdx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      toCnt <= '0;
    end else begin
      state <= stateNext;
      toCnt <= toCntNext;
    end
  end

  // Byte handling has priority over the timeout; clear_all overrides both.
  always_comb begin
    stateNext = state;
    toCntNext = toCnt;
    setKey    = 1'b0;
    clrKey    = 1'b0;
    if (bus.clear_all) begin
      stateNext = IDLE;
      toCntNext = '0;
    end else if (bus.ps2_byte_valid) begin
      toCntNext = '0;
      stateNext = IDLE;
      case (state)
        IDLE: begin
          if (bus.ps2_byte == scBreak) begin
            stateNext = BRK;
            toCntNext = CNT_LOAD;
          end else if (bus.ps2_byte == scExtend) begin
            stateNext = EXT;
            toCntNext = CNT_LOAD;
          end else begin
            setKey = decHit && !keyHeld;
          end
        end
        BRK: begin
          if (bus.ps2_byte == scBreak) begin
            stateNext = BRK;
            toCntNext = CNT_LOAD;
          end else if (bus.ps2_byte == scExtend) begin
            stateNext = EXT_BRK;
            toCntNext = CNT_LOAD;
          end else begin
            clrKey = keyHeld;
          end
        end
        EXT: begin
          if (bus.ps2_byte == scBreak) begin
            stateNext = EXT_BRK;
            toCntNext = CNT_LOAD;
          end
        end
        default: ;
      endcase
    end else if (state != IDLE) begin
      if (toCnt == '0) begin
        stateNext = IDLE;
      end else begin
        toCntNext = toCnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyState <= '0;
    end else if (bus.clear_all) begin
      keyState <= '0;
    end else if (setKey) begin
      keyState[decIdx] <= 1'b1;
    end else if (clrKey) begin
      keyState[decIdx] <= 1'b0;
    end
  end

  assign bus.key_state = keyState;

`ifdef KEY_TRACKER_EVENT_EN
  logic                 evValid;
  logic [KEY_IDX_W-1:0] evIndex;
  logic                 evPress;

  // Index/press hold their last value between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evValid <= 1'b0;
      evIndex <= '0;
      evPress <= 1'b0;
    end else begin
      evValid <= setKey || clrKey;
      if (setKey || clrKey) begin
        evIndex <= decIdx;
        evPress <= setKey;
      end
    end
  end

  assign bus.key_event_valid = evValid;
  assign bus.key_event_index = evIndex;
  assign bus.key_event_press = evPress;
`else
  assign bus.key_event_valid = 1'b0;
  assign bus.key_event_index = '0;
  assign bus.key_event_press = 1'b0;
`endif

endmodule
